// File: rtl/sim_term_monitor_pkg.sv
// optimsoc_sim_package
// Shared definitions for the simulation-control monitor:
//   - l.nop hook encodings (prefix and K values for exit / putc)
//   - char_entry_t: one output byte tagged with its source core
//   - core_idx_width(): width of a core index (minimum 1 bit)
package optimsoc_sim_package;

    localparam logic [15:0] NOP_PREFIX = 16'h1500;
    localparam logic [15:0] NOP_EXIT   = 16'h0001;
    localparam logic [15:0] NOP_PUTC   = 16'h0004;

    // Up to 64 cores, so a 6-bit core tag covers every configuration.
    localparam int MAX_CORE_W = 6;

    typedef struct packed {
        logic [7:0]            data;
        logic [MAX_CORE_W-1:0] core;
    } char_entry_t;

    function automatic int core_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sim_term_monitor_if.sv
// sim_term_monitor_if
// Merged character output stream of the monitor.
//   char_valid : byte available (driven by master)
//   char_ready : sink accepts the byte (driven by slave)
//   char_data  : byte value
//   char_core  : source core index
// Handshake: a byte transfers on a rising clk edge where char_valid and
// char_ready are both high. While char_valid is high and char_ready low,
// char_valid, char_data and char_core hold their values. char_ready may
// depend on nothing from the master; char_valid never waits for char_ready.
interface sim_term_monitor_if #(
    parameter int NUM_CORES = 4
);
    import optimsoc_sim_package::*;

    localparam int CORE_W = core_idx_width(NUM_CORES);

    logic              char_valid;
    logic              char_ready;
    logic [7:0]        char_data;
    logic [CORE_W-1:0] char_core;

    modport master (
        output char_valid,
        output char_data,
        output char_core,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_data,
        input  char_core,
        output char_ready
    );

endinterface

// File: rtl/sim_term_monitor_char_fifo.sv
// sim_char_fifo
// Single-clock FIFO for one core's putc bytes.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full unless popped)
//   pop, dout  : read request and head-of-queue data (dout valid when !empty)
//   full, empty: occupancy flags
// A push while full is accepted if a pop happens in the same cycle.
module sim_char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sim_term_monitor.sv
// sim_term_monitor
// Multi-core simulation-control monitor. Tracks each core's r3 from the
// retired-instruction trace, decodes l.nop hooks (K=1 exit, K=4 putc),
// merges per-core putc bytes into one round-robin arbitrated stream and
// raises terminate once all cores exited and all output drained.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   trace_valid/insn/wben/wbreg/wbdata : per-core retire trace (core c at slice c)
//   char_if (master)        : merged byte stream {char_valid, char_ready, char_data, char_core}
//   exit_mask               : sticky per-core exit flag
//   exit_code               : r3 of first core exiting with nonzero r3
//   overflow                : sticky per-core putc drop flag
//   terminate               : sticky simulation-end flag
//   timeout                 : sticky watchdog flag
// Macro OPTIMSOC_SIM_TERM_TIMEOUT_EN builds the idle watchdog; without it
// timeout is tied to 0.
module sim_term_monitor
    import optimsoc_sim_package::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CORES-1:0]    trace_valid,
    input  logic [NUM_CORES*32-1:0] trace_insn,
    input  logic [NUM_CORES-1:0]    trace_wben,
    input  logic [NUM_CORES*5-1:0]  trace_wbreg,
    input  logic [NUM_CORES*32-1:0] trace_wbdata,
    sim_term_monitor_if.master      char_if,
    output logic [NUM_CORES-1:0]    exit_mask,
    output logic [31:0]             exit_code,
    output logic [NUM_CORES-1:0]    overflow,
    output logic                    terminate,
    output logic                    timeout
);
    localparam int CORE_W = core_idx_width(NUM_CORES);

    logic [31:0]          r3_q [NUM_CORES];
    logic [NUM_CORES-1:0] hook_exit;
    logic [NUM_CORES-1:0] hook_putc;
    logic [NUM_CORES-1:0] fifo_pop;
    logic [NUM_CORES-1:0] fifo_full;
    logic [NUM_CORES-1:0] fifo_empty;
    logic [7:0]           fifo_dout [NUM_CORES];

    logic                 code_latched;
    logic                 code_hit;
    logic [31:0]          code_sel;

    logic                 out_valid_q;
    char_entry_t          out_q;
    logic [CORE_W-1:0]    rr_ptr;
    logic                 load;
    logic                 grant_any;
    logic [CORE_W-1:0]    grant_idx;
    logic [7:0]           grant_data;
    logic [CORE_W-1:0]    rr_next;
    int                   arb_idx;

    logic                 term_cond;
    logic                 timeout_hit;

    // ---------------- hook decode ----------------
    always_comb begin
        hook_exit = '0;
        hook_putc = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (trace_valid[c] && trace_insn[32*c+16 +: 16] == NOP_PREFIX) begin
                hook_exit[c] = (trace_insn[32*c +: 16] == NOP_EXIT);
                hook_putc[c] = (trace_insn[32*c +: 16] == NOP_PUTC);
            end
        end
    end

    // ---------------- r3 shadows ----------------
    // Hooks read r3_q before this edge's update, i.e. the pre-retire value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CORES; c++) r3_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CORES; c++) begin
                if (trace_valid[c] && trace_wben[c] && trace_wbreg[5*c +: 5] == 5'd3)
                    r3_q[c] <= trace_wbdata[32*c +: 32];
            end
        end
    end

    // ---------------- exit code select ----------------
    // Several cores may exit in one cycle; the lowest index wins.
    always_comb begin
        code_hit = 1'b0;
        code_sel = '0;
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            if (hook_exit[c] && !exit_mask[c] && r3_q[c] != 32'd0) begin
                code_hit = 1'b1;
                code_sel = r3_q[c];
            end
        end
    end

    // ---------------- per-core FIFOs ----------------
    for (genvar c = 0; c < NUM_CORES; c++) begin : g_fifo
        sim_char_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (8)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (hook_putc[c]),
            .din   (r3_q[c][7:0]),
            .pop   (fifo_pop[c]),
            .dout  (fifo_dout[c]),
            .full  (fifo_full[c]),
            .empty (fifo_empty[c])
        );
    end

    // ---------------- round-robin arbiter ----------------
    // rr_ptr is the first core considered; it moves to one past the winner.
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        arb_idx    = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            arb_idx = int'(rr_ptr) + i;
            if (arb_idx >= NUM_CORES) arb_idx = arb_idx - NUM_CORES;
            if (!grant_any && !fifo_empty[arb_idx]) begin
                grant_any  = 1'b1;
                grant_idx  = CORE_W'(arb_idx);
                grant_data = fifo_dout[arb_idx];
            end
        end
    end

    assign rr_next = (grant_idx == CORE_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;

    // Output register reloads when empty or when its byte leaves this edge.
    assign load = !out_valid_q || char_if.char_ready;

    always_comb begin
        fifo_pop = '0;
        if (load && grant_any) fifo_pop[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            out_valid_q <= grant_any;
            if (grant_any) begin
                out_q.data <= grant_data;
                out_q.core <= MAX_CORE_W'(grant_idx);
                rr_ptr     <= rr_next;
            end
        end
    end

    assign char_if.char_valid = out_valid_q;
    assign char_if.char_data  = out_q.data;
    assign char_if.char_core  = out_q.core[CORE_W-1:0];

    // Upper tag bits are zero for small configurations.
    logic core_tag_unused;
    assign core_tag_unused = ^out_q.core;

    // ---------------- flags ----------------
    assign term_cond = (&exit_mask) && (&fifo_empty) && !out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exit_mask    <= '0;
            exit_code    <= '0;
            code_latched <= 1'b0;
            overflow     <= '0;
            terminate    <= 1'b0;
        end else begin
            exit_mask <= exit_mask | hook_exit;
            if (!code_latched && code_hit) begin
                exit_code    <= code_sel;
                code_latched <= 1'b1;
            end
            overflow  <= overflow | (hook_putc & fifo_full & ~fifo_pop);
            terminate <= terminate | term_cond | timeout_hit;
        end
    end

    // ---------------- idle watchdog ----------------
`ifdef OPTIMSOC_SIM_TERM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] idle_cnt;

    assign timeout_hit = (idle_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (|trace_valid)      idle_cnt <= '0;
            else if (!timeout_hit) idle_cnt <= idle_cnt + 1'b1;
            if (timeout_hit)       timeout  <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;

    logic cfg_unused;
    assign cfg_unused = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_sim_term_monitor.sv
module tb_sim_term_monitor;
    localparam int NC    = 4;
    localparam int DEPTH = 8;
    localparam int TO    = 100;

    localparam logic [31:0] INSN_PUTC = 32'h1500_0004;
    localparam logic [31:0] INSN_EXIT = 32'h1500_0001;
    localparam logic [31:0] INSN_ALU  = 32'hE000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]    trace_valid;
    logic [NC*32-1:0] trace_insn;
    logic [NC-1:0]    trace_wben;
    logic [NC*5-1:0]  trace_wbreg;
    logic [NC*32-1:0] trace_wbdata;
    logic [NC-1:0]    exit_mask;
    logic [31:0]      exit_code;
    logic [NC-1:0]    overflow;
    logic             terminate;
    logic             timeout;

    sim_term_monitor_if #(.NUM_CORES(NC)) cif();

    sim_term_monitor #(
        .NUM_CORES      (NC),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trace_valid  (trace_valid),
        .trace_insn   (trace_insn),
        .trace_wben   (trace_wben),
        .trace_wbreg  (trace_wbreg),
        .trace_wbdata (trace_wbdata),
        .char_if      (cif),
        .exit_mask    (exit_mask),
        .exit_code    (exit_code),
        .overflow     (overflow),
        .terminate    (terminate),
        .timeout      (timeout)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];   // {core[1:0], data[7:0]}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge; a byte with valid&ready here is
    // accepted on the next rising edge. Also checks hold-while-stalled.
    logic       held;
    logic [9:0] held_val;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", {31'd0, cif.char_valid}, 32'd1);
                check("stall_data", {22'd0, cif.char_core, cif.char_data}, {22'd0, held_val});
            end
            held = 1'b0;
            if (cif.char_valid && cif.char_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL char_unexpected: got core %0d data %h expected none", cif.char_core, cif.char_data);
                end else begin
                    check("char", {22'd0, cif.char_core, cif.char_data}, {22'd0, exp_q.pop_front()});
                end
            end else if (cif.char_valid) begin
                held     = 1'b1;
                held_val = {cif.char_core, cif.char_data};
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All driver tasks start and end 2 time units after a rising edge.
    task automatic clear_trace();
        trace_valid  = '0;
        trace_insn   = '0;
        trace_wben   = '0;
        trace_wbreg  = '0;
        trace_wbdata = '0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int c, input logic [31:0] insn, input logic wben,
                         input logic [4:0] wreg, input logic [31:0] wdata);
        trace_valid[c]            = 1'b1;
        trace_insn[32*c +: 32]    = insn;
        trace_wben[c]             = wben;
        trace_wbreg[5*c +: 5]     = wreg;
        trace_wbdata[32*c +: 32]  = wdata;
        @(posedge clk);
        #2;
        clear_trace();
    endtask

    task automatic set_r3(input int c, input logic [31:0] v);
        drive(c, INSN_ALU, 1'b1, 5'd3, v);
    endtask

    task automatic putc_multi(input logic [NC-1:0] mask);
        for (int c = 0; c < NC; c++) begin
            if (mask[c]) begin
                trace_valid[c]         = 1'b1;
                trace_insn[32*c +: 32] = INSN_PUTC;
            end
        end
        @(posedge clk);
        #2;
        clear_trace();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        clear_trace();
        cif.char_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", {31'd0, cif.char_valid}, 32'd0);
        check("rst_exit_mask", {28'd0, exit_mask}, 32'd0);
        check("rst_exit_code", exit_code, 32'd0);
        check("rst_overflow", {28'd0, overflow}, 32'd0);
        check("rst_terminate", {31'd0, terminate}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        rst_n = 1'b1;

        // Idle watchdog from reset release (or its absence).
`ifdef OPTIMSOC_SIM_TERM_TIMEOUT_EN
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("to_before", {31'd0, timeout}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("to_fire", {31'd0, timeout}, 32'd1);
        check("to_term", {31'd0, terminate}, 32'd1);
        check("to_exit_mask", {28'd0, exit_mask}, 32'd0);
        @(posedge clk);
        #2;
`else
        repeat (120) idle_cycle();
        check("no_timeout", {31'd0, timeout}, 32'd0);
        check("no_term", {31'd0, terminate}, 32'd0);
`endif

        // Test 1: single putc latency.
        do_reset();
        cif.char_ready = 1'b1;
        set_r3(0, 32'h41);
        exp_q.push_back({2'd0, 8'h41});
        drive(0, INSN_PUTC, 1'b0, 5'd0, 32'd0);
        check("lat_e0_valid", {31'd0, cif.char_valid}, 32'd0);
        idle_cycle();
        check("lat_e1_valid", {31'd0, cif.char_valid}, 32'd1);
        check("lat_e1_data", {24'd0, cif.char_data}, 32'h41);
        check("lat_e1_core", {30'd0, cif.char_core}, 32'd0);
        repeat (3) idle_cycle();

        // Test 2: four cores putc together, round-robin order, no bubbles.
        do_reset();
        cif.char_ready = 1'b1;
        for (int c = 0; c < NC; c++) begin
            trace_valid[c]           = 1'b1;
            trace_insn[32*c +: 32]   = INSN_ALU;
            trace_wben[c]            = 1'b1;
            trace_wbreg[5*c +: 5]    = 5'd3;
            trace_wbdata[32*c +: 32] = 32'h30 + c;
        end
        idle_cycle();
        clear_trace();
        for (int c = 0; c < NC; c++) exp_q.push_back({2'(c), 8'(8'h30 + c)});
        putc_multi(4'b1111);
        for (int k = 0; k < NC; k++) begin
            idle_cycle();
            check("burst_valid", {31'd0, cif.char_valid}, 32'd1);
            check("burst_core", {30'd0, cif.char_core}, 32'(k));
        end
        // Pointer wrapped past core 3: core 0 is served before core 3.
        exp_q.push_back({2'd0, 8'h30});
        exp_q.push_back({2'd3, 8'h33});
        putc_multi(4'b1001);
        repeat (5) idle_cycle();
        check("rr_drain", exp_q.size(), 32'd0);

        // Test 3: fill core 1 with the sink stalled; full-and-pop accepts,
        // a push into a full FIFO without pop is dropped.
        // r3 is rewritten by the putc itself; the hook uses the old value.
        do_reset();
        cif.char_ready = 1'b0;
        set_r3(1, 32'h60);
        for (int i = 0; i <= 10; i++) begin
            if (i == 9)  cif.char_ready = 1'b1;
            if (i == 10) cif.char_ready = 1'b0;
            if (i <= 9) exp_q.push_back({2'd1, 8'(8'h60 + i)});
            drive(1, INSN_PUTC, 1'b1, 5'd3, 32'h61 + i);
            if (i == 8) check("ovf_at_full", {28'd0, overflow}, 32'd0);
            if (i == 9) check("ovf_fullpop", {28'd0, overflow}, 32'd0);
            if (i == 10) check("ovf_drop", {28'd0, overflow}, 32'b0010);
        end
        cif.char_ready = 1'b1;
        repeat (14) idle_cycle();
        check("fill_drain", exp_q.size(), 32'd0);

        // Test 4: exits with r3 0,5,7,0 while core 2 still has 3 bytes queued.
        do_reset();
        cif.char_ready = 1'b0;
        set_r3(2, 32'h61);
        drive(2, INSN_PUTC, 1'b1, 5'd3, 32'h62);
        drive(2, INSN_PUTC, 1'b1, 5'd3, 32'h63);
        drive(2, INSN_PUTC, 1'b0, 5'd0, 32'd0);
        exp_q.push_back({2'd2, 8'h61});
        exp_q.push_back({2'd2, 8'h62});
        exp_q.push_back({2'd2, 8'h63});
        drive(0, INSN_EXIT, 1'b0, 5'd0, 32'd0);
        set_r3(1, 32'd5);
        drive(1, INSN_EXIT, 1'b0, 5'd0, 32'd0);
        set_r3(2, 32'd7);
        drive(2, INSN_EXIT, 1'b0, 5'd0, 32'd0);
        drive(3, INSN_EXIT, 1'b0, 5'd0, 32'd0);
        check("exit_mask", {28'd0, exit_mask}, 32'hF);
        check("exit_code", exit_code, 32'd5);
        check("term_pending", {31'd0, terminate}, 32'd0);
        set_r3(2, 32'd9);
        drive(2, INSN_EXIT, 1'b0, 5'd0, 32'd0);
        check("exit_code_frozen", exit_code, 32'd5);
        cif.char_ready = 1'b1;
        idle_cycle();
        check("term_a1", {31'd0, terminate}, 32'd0);
        idle_cycle();
        check("term_a2", {31'd0, terminate}, 32'd0);
        idle_cycle();
        check("term_a3", {31'd0, terminate}, 32'd0);
        idle_cycle();
        check("term_rise", {31'd0, terminate}, 32'd1);
        check("term_drain", exp_q.size(), 32'd0);
        repeat (2) idle_cycle();
        check("term_sticky", {31'd0, terminate}, 32'd1);

        // Test 6: reset while bytes are queued.
        do_reset();
        cif.char_ready = 1'b0;
        set_r3(0, 32'h71);
        drive(0, INSN_PUTC, 1'b1, 5'd3, 32'h72);
        drive(0, INSN_PUTC, 1'b0, 5'd0, 32'd0);
        drive(0, INSN_EXIT, 1'b0, 5'd0, 32'd0);
        check("pre_rst_valid", {31'd0, cif.char_valid}, 32'd1);
        check("pre_rst_exit", {28'd0, exit_mask}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, cif.char_valid}, 32'd0);
        check("mid_rst_data", {24'd0, cif.char_data}, 32'd0);
        check("mid_rst_exit", {28'd0, exit_mask}, 32'd0);
        check("mid_rst_code", exit_code, 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cif.char_ready = 1'b1;
        repeat (8) idle_cycle();
        check("post_rst_quiet", {31'd0, cif.char_valid}, 32'd0);
        // Shadow was cleared: putc without a prior write emits 0x00.
        exp_q.push_back({2'd0, 8'h00});
        drive(0, INSN_PUTC, 1'b0, 5'd0, 32'd0);
        repeat (4) idle_cycle();
        check("post_rst_drain", exp_q.size(), 32'd0);
        check("end_overflow", {28'd0, overflow}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
